// File: rtl/mux64_scan_ctrl.sv
// Bit-serial scan controller: captures a 64-bit word and streams the selected
// bits over valid/ready while stepping the 6-bit select through a programmed range.
module mux64_scan_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] data_in,
    input  logic [5:0]  len,
    input  logic        msb_first,
    input  logic        abort,
    output logic        busy,
    output logic [5:0]  sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_bit,
    output logic        out_last,
    output logic        done
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned SEL_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [DATA_W-1:0]  r_shadow;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_len_q;
    logic               r_dir_q;

    logic               w_accept;
    logic               w_beat;
    logic               w_last;

    assign w_accept = (r_state == ST_IDLE) && start && !abort;
    assign w_beat   = (r_state == ST_SHIFT) && out_ready;
    assign w_last   = (r_cnt == r_len_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_SHIFT;
            ST_SHIFT: begin
                if (abort)                w_next_state = ST_IDLE;
                else if (w_beat && w_last) w_next_state = ST_DONE;
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Capture on accepted start, advance on a non-final beat; abort freezes the datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_len_q  <= '0;
            r_dir_q  <= 1'b0;
        end else if (w_accept) begin
            r_shadow <= data_in;
            r_len_q  <= len;
            r_dir_q  <= msb_first;
            r_cnt    <= '0;
            r_sel    <= msb_first ? len : '0;
        end else if (w_beat && !w_last && !abort) begin
            r_cnt <= r_cnt + SEL_W'(1);
            r_sel <= r_dir_q ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        busy      = (r_state != ST_IDLE);
        out_valid = (r_state == ST_SHIFT);
        out_last  = (r_state == ST_SHIFT) && w_last;
        done      = (r_state == ST_DONE);
        sel       = r_sel;
        out_bit   = r_shadow[r_sel];
    end

endmodule

// File: tb/tb_mux64_scan_ctrl.sv
// Directed self-checking bench for mux64_scan_ctrl.
module tb_mux64_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] data_in;
    logic [5:0]  len;
    logic        msb_first;
    logic        abort;
    logic        busy;
    logic [5:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic        out_bit;
    logic        out_last;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    mux64_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data_in   (data_in),
        .len       (len),
        .msb_first (msb_first),
        .abort     (abort),
        .busy      (busy),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(busy),      64'd0);
        check({tag, "_sel"},   64'(sel),       64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_bit"},   64'(out_bit),   64'd0);
        check({tag, "_last"},  64'(out_last),  64'd0);
        check({tag, "_done"},  64'(done),      64'd0);
    endtask

    // Issue start in the current IDLE cycle; returns in the first SHIFT cycle
    task automatic start_xfer(input logic [63:0] d, input logic [5:0] l, input logic m);
        data_in   = d;
        len       = l;
        msb_first = m;
        start     = 1'b1;
        step();
        start     = 1'b0;
        data_in   = 64'd0;
        len       = 6'd0;
        msb_first = 1'b0;
    endtask

    logic [63:0] word;
    logic [7:0]  msb_seq;
    logic [6:0]  rdy_pat;
    int          k;

    initial begin
        rst = 1'b1; start = 1'b0; data_in = 64'd0; len = 6'd0;
        msb_first = 1'b0; abort = 1'b0; out_ready = 1'b1;
        #1;
        check_all_zero("reset");
        step();
        step();
        rst = 1'b0;
        step();
        check_all_zero("post_reset");

        // start together with abort in IDLE stays IDLE
        data_in = 64'hFFFF_FFFF_FFFF_FFFF; len = 6'd5; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0; data_in = 64'd0; len = 6'd0;
        check("start_abort_busy",  64'(busy),      64'd0);
        check("start_abort_valid", 64'(out_valid), 64'd0);

        // Reset mid-transfer at bit 10
        word = 64'h0123_4567_89AB_CDEF;
        start_xfer(word, 6'd63, 1'b0);
        for (int i = 0; i < 10; i++) step();
        check("rst_mid_sel",   64'(sel),     64'd10);
        check("rst_mid_bit",   64'(out_bit), 64'(word[10]));
        #3 rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_after_busy", 64'(busy), 64'd0);
            check("rst_after_done", 64'(done), 64'd0);
        end

        // LSB-first, full word
        word = 64'hF0F0_0000_0000_00A5;
        start_xfer(word, 6'd63, 1'b0);
        check("lsb_b0", 64'(out_bit), 64'd1);
        for (int i = 0; i < 64; i++) begin
            check("lsb_valid", 64'(out_valid), 64'd1);
            check("lsb_sel",   64'(sel),       64'(i));
            check("lsb_bit",   64'(out_bit),   64'(word[6'(i)]));
            check("lsb_last",  64'(out_last),  64'(i == 63));
            step();
        end
        check("lsb_done",       64'(done),      64'd1);
        check("lsb_done_valid", 64'(out_valid), 64'd0);
        check("lsb_done_busy",  64'(busy),      64'd1);
        step();
        check("lsb_idle_done",  64'(done),      64'd0);
        check("lsb_idle_busy",  64'(busy),      64'd0);

        // MSB-first, short
        msb_seq = 8'b1011_0100;
        start_xfer(64'h0000_0000_0000_00B4, 6'd7, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("msb_sel",  64'(sel),      64'(7 - i));
            check("msb_bit",  64'(out_bit),  64'(msb_seq[3'(7 - i)]));
            check("msb_last", 64'(out_last), 64'(i == 7));
            step();
        end
        check("msb_done", 64'(done), 64'd1);
        step();

        // Backpressure
        word    = 64'h0000_0000_0000_000A;
        rdy_pat = 7'b110_1001;
        start_xfer(word, 6'd3, 1'b0);
        k = 0;
        for (int c = 0; c < 7; c++) begin
            out_ready = rdy_pat[3'(c)];
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_sel",   64'(sel),       64'(k));
            check("bp_bit",   64'(out_bit),   64'(word[6'(k)]));
            check("bp_last",  64'(out_last),  64'(k == 3));
            step();
            if (rdy_pat[3'(c)]) k++;
        end
        out_ready = 1'b1;
        check("bp_beats", 64'(k),    64'd4);
        check("bp_done",  64'(done), 64'd1);
        step();

        // Abort after 5 beats, with an ignored start during SHIFT
        word = 64'h0000_0000_0000_ABCD;
        start_xfer(word, 6'd15, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1; data_in = 64'hFFFF_FFFF_FFFF_FFFF; len = 6'd0; msb_first = 1'b1;
            end
            check("ab_sel",  64'(sel),     64'(i));
            check("ab_bit",  64'(out_bit), 64'(word[6'(i)]));
            check("ab_busy", 64'(busy),    64'd1);
            step();
            start = 1'b0; data_in = 64'd0; len = 6'd0; msb_first = 1'b0;
        end
        check("ab_sel5",  64'(sel),      64'd5);
        check("ab_bit5",  64'(out_bit),  64'(word[5]));
        check("ab_last5", 64'(out_last), 64'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_busy_after",  64'(busy),      64'd0);
        check("ab_valid_after", 64'(out_valid), 64'd0);
        check("ab_done_after",  64'(done),      64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ab_no_done", 64'(done), 64'd0);
            check("ab_idle",    64'(busy), 64'd0);
        end

        // Single bit, then back-to-back start at N+3
        start_xfer(64'h1, 6'd0, 1'b1);
        check("one_valid", 64'(out_valid), 64'd1);
        check("one_sel",   64'(sel),       64'd0);
        check("one_bit",   64'(out_bit),   64'd1);
        check("one_last",  64'(out_last),  64'd1);
        step();
        check("one_done",  64'(done),      64'd1);
        check("one_valid_n2", 64'(out_valid), 64'd0);
        step();
        check("one_idle",  64'(busy),      64'd0);
        check("one_done_n3", 64'(done),    64'd0);
        start_xfer(64'h0000_0000_0000_0004, 6'd2, 1'b0);
        check("b2b_busy",  64'(busy),      64'd1);
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_sel",   64'(sel),       64'd0);
        check("b2b_bit",   64'(out_bit),   64'd0);
        step();
        step();
        check("b2b_sel2",  64'(sel),       64'd2);
        check("b2b_bit2",  64'(out_bit),   64'd1);
        check("b2b_last2", 64'(out_last),  64'd1);
        step();
        check("b2b_done",  64'(done),      64'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
